// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared limits, reset divisor, channel settings type and helpers
//   NUM_CH_MIN/MAX, WIDTH_MIN/MAX : legal parameter ranges for clk_div_prog
//   DEF_DIV                       : post-reset divisor (high count is DEF_DIV/2)
//   chan_cfg_t                    : one channel's {div, high} setting pair
package clk_div_pkg;
    localparam int NUM_CH_MIN = 1;
    localparam int NUM_CH_MAX = 8;
    localparam int WIDTH_MIN  = 4;
    localparam int WIDTH_MAX  = 32;
    localparam int DEF_DIV    = 10;

    typedef logic [WIDTH_MAX-1:0] word_t;

    // Settings are carried at the maximum width; narrower channels
    // zero-extend into it so every comparison is done at one width.
    typedef struct packed {
        word_t div;
        word_t high;
    } chan_cfg_t;

    // A divisor below 2 cannot form a period, so it runs as 2.
    function automatic word_t eff_div(input word_t d);
        return (d < word_t'(2)) ? word_t'(2) : d;
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one programmable divider channel with glitch-free reload
//   clk_in   : clock, all logic on rising edge
//   rst      : asynchronous active-high reset
//   en       : run enable
//   load     : one-cycle request to capture div_in/high_in
//   div_in   : requested period in clk_in cycles
//   high_in  : requested high-phase length in clk_in cycles
//   clk_out  : registered divided clock
//   tick     : pulse coincident with each 0->1 of clk_out
//   load_ack : pulse in the first cycle new settings are active
module clk_div_chan #(
    parameter int WIDTH   = 16,
    parameter int DEF_DIV = 10
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             clk_out,
    output logic             tick,
    output logic             load_ack
);
    import clk_div_pkg::*;

    localparam chan_cfg_t RST_CFG = '{div: word_t'(DEF_DIV), high: word_t'(DEF_DIV / 2)};

    chan_cfg_t        act;
    chan_cfg_t        shd;
    chan_cfg_t        req;
    chan_cfg_t        nxt;
    logic             pend;
    logic             wrap;
    logic             upd;
    logic             hi;
    logic [WIDTH-1:0] cnt;

    // Settings change only at a period boundary (wrap) or while stopped,
    // so a running output never sees a partial period. A load landing on
    // the wrap itself is applied directly instead of going through shadow.
    always_comb begin
        req  = '{div: word_t'(div_in), high: word_t'(high_in)};
        nxt  = load ? req : shd;
        wrap = en && (word_t'(cnt) == eff_div(act.div) - word_t'(1));
        upd  = (wrap && (pend || load)) || (!en && pend);
        hi   = en && (word_t'(cnt) < act.high);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            act      <= RST_CFG;
            shd      <= RST_CFG;
            pend     <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            cnt      <= (!en || wrap) ? '0 : cnt + 1'b1;
            clk_out  <= hi;
            tick     <= hi && !clk_out;
            load_ack <= upd;
            if (upd) begin
                act  <= nxt;
                shd  <= nxt;
                pend <= 1'b0;
            end else if (load) begin
                shd  <= req;
                pend <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: NUM_CH independent programmable clock dividers
//   clk_in   : clock, all logic on rising edge
//   rst      : asynchronous active-high reset
//   en       : per-channel run enable
//   load     : per-channel one-cycle settings capture request
//   div_val  : per-channel period, channel i at [i*WIDTH +: WIDTH]
//   high_val : per-channel high-phase length, same slicing
//   clk_out  : per-channel registered divided clock
//   tick     : per-channel rising-edge pulse of clk_out
//   load_ack : per-channel pulse when new settings become active
module clk_div_prog #(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 16,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] div_val,
    input  logic [NUM_CH*WIDTH-1:0] high_val,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       load_ack
);
    import clk_div_pkg::*;

    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .WIDTH  (WIDTH),
            .DEF_DIV(DEF_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .rst     (rst),
            .en      (en[i]),
            .load    (load[i]),
            .div_in  (div_val[i*WIDTH +: WIDTH]),
            .high_in (high_val[i*WIDTH +: WIDTH]),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .load_ack(load_ack[i])
        );
    end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scoreboard bench for clk_div_prog
module tb_clk_div_prog;
    localparam int NC  = 2;
    localparam int W   = 16;
    localparam int DEF = 10;

    logic            clk_in = 1'b0;
    logic            rst    = 1'b1;
    logic [NC-1:0]   en     = '0;
    logic [NC-1:0]   load   = '0;
    logic [NC*W-1:0] div_val  = '0;
    logic [NC*W-1:0] high_val = '0;
    logic [NC-1:0]   clk_out;
    logic [NC-1:0]   tick;
    logic [NC-1:0]   load_ack;

    always #5 clk_in = ~clk_in;

    clk_div_prog #(.NUM_CH(NC), .WIDTH(W), .DEF_DIV(DEF)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_val (div_val),
        .high_val(high_val),
        .clk_out (clk_out),
        .tick    (tick),
        .load_ack(load_ack)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [3*NC-1:0] sb_q[$];

    int m_pos[NC], m_per[NC], m_hl[NC], m_sper[NC], m_shl[NC];
    bit m_pend[NC], m_co[NC];
    int acks[NC], ticks[NC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: position within period, applied settings swap at boundary or while idle.
    task automatic model_step();
        logic [NC-1:0] co, tk, ak;
        co = '0; tk = '0; ak = '0;
        for (int c = 0; c < NC; c++) begin
            int dv, hv, len;
            bit last, swap, now_hi;
            dv = int'(div_val[c*W +: W]);
            hv = int'(high_val[c*W +: W]);
            if (rst) begin
                m_pos[c] = 0; m_per[c] = DEF; m_hl[c] = DEF / 2;
                m_sper[c] = DEF; m_shl[c] = DEF / 2; m_pend[c] = 0; m_co[c] = 0;
            end else begin
                len    = (m_per[c] > 1) ? m_per[c] : 2;
                last   = en[c] && (m_pos[c] + 1 == len);
                swap   = en[c] ? (last && (m_pend[c] || load[c])) : m_pend[c];
                now_hi = en[c] && (m_pos[c] < m_hl[c]);
                co[c]  = now_hi;
                tk[c]  = now_hi && !m_co[c];
                ak[c]  = swap;
                m_co[c]  = now_hi;
                m_pos[c] = (en[c] && !last) ? m_pos[c] + 1 : 0;
                if (load[c]) begin
                    m_sper[c] = dv; m_shl[c] = hv; m_pend[c] = 1;
                end
                if (swap) begin
                    m_per[c] = m_sper[c]; m_hl[c] = m_shl[c]; m_pend[c] = 0;
                end
            end
        end
        sb_q.push_back({co, tk, ak});
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk_in);
        #1;
        if (sb_q.size() == 0) check("sb_empty", 1, 0);
        else check("outs", {clk_out, tick, load_ack}, sb_q.pop_front());
        for (int c = 0; c < NC; c++) begin
            acks[c]  += int'(load_ack[c]);
            ticks[c] += int'(tick[c]);
        end
    endtask

    task automatic set_cfg(input int c, input int d, input int h);
        div_val[c*W +: W]  = W'(d);
        high_val[c*W +: W] = W'(h);
    endtask

    task automatic pulse_load(input int c, input int d, input int h);
        set_cfg(c, d, h);
        load[c] = 1'b1;
        cyc();
        load[c] = 1'b0;
    endtask

    task automatic wait_ack(input int c);
        bit ok;
        ok = load_ack[c];
        for (int i = 0; i < 64 && !ok; i++) begin
            cyc();
            ok = load_ack[c];
        end
        check("ack_wait", ok, 1);
    endtask

    task automatic wait_tick(input int c);
        bit ok;
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            cyc();
            ok = tick[c];
        end
        check("tick_wait", ok, 1);
    endtask

    task automatic measure(input int c, input int per, input int hi, input string tag);
        int n, h;
        wait_tick(c);
        n = 0; h = 0;
        do begin
            if (clk_out[c]) h++;
            cyc();
            n++;
        end while (!tick[c] && n < 64);
        check({tag, "_per"}, n, per);
        check({tag, "_hi"}, h, hi);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, t0;
        en = '1;
        repeat (3) cyc();
        check("rst_outs", {clk_out, tick, load_ack}, 0);
        rst = 1'b0;
        measure(0, 10, 5, "def0");
        measure(1, 10, 5, "def1");

        repeat (3) cyc();
        a0 = acks[0];
        pulse_load(0, 7, 2);
        wait_ack(0);
        check("ack_mid", acks[0] - a0, 1);
        measure(0, 7, 2, "d7");
        measure(0, 7, 2, "d7b");

        pulse_load(0, 1, 1);
        wait_ack(0);
        measure(0, 2, 1, "d1");
        pulse_load(0, 0, 1);
        wait_ack(0);
        measure(0, 2, 1, "d0");
        pulse_load(0, 5, 0);
        wait_ack(0);
        cyc();
        t0 = ticks[0];
        repeat (20) cyc();
        check("h0_ticks", ticks[0] - t0, 0);
        check("h0_co", clk_out[0], 0);
        pulse_load(0, 4, 9);
        wait_ack(0);
        cyc();
        t0 = ticks[0];
        repeat (12) cyc();
        check("hfull_ticks", ticks[0] - t0, 0);
        check("hfull_co", clk_out[0], 1);

        pulse_load(0, 20, 10);
        wait_ack(0);
        repeat (2) cyc();
        a0 = acks[0];
        pulse_load(0, 12, 6);
        repeat (2) cyc();
        pulse_load(0, 4, 2);
        repeat (30) cyc();
        check("ack_double", acks[0] - a0, 1);
        measure(0, 4, 2, "d4");

        repeat (2) cyc();
        en[0] = 1'b0;
        cyc();
        check("dis_co", clk_out[0], 0);
        pulse_load(0, 6, 3);
        cyc();
        check("dis_ack", load_ack[0], 1);
        en[0] = 1'b1;
        cyc();
        check("reen_tick", tick[0], 1);
        measure(0, 6, 3, "d6");

        pulse_load(0, 3, 1);
        wait_ack(0);
        measure(0, 3, 1, "d3");
        wait_tick(1);
        a1 = acks[1];
        pulse_load(1, 8, 4);
        repeat (3) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        check("rst_noack", acks[1] - a1, 0);
        rst = 1'b0;
        measure(0, 10, 5, "post0");
        measure(1, 10, 5, "post1");

        repeat (300) begin
            for (int c = 0; c < NC; c++) begin
                en[c]   = ($urandom_range(0, 15) != 0);
                load[c] = ($urandom_range(0, 7) == 0);
                set_cfg(c, int'($urandom_range(0, 12)), int'($urandom_range(0, 13)));
            end
            cyc();
        end
        load = '0;
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, giving the number of independent divider channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 16, giving the counter and divisor width in bits (4..32).
REQ-003 SHALL have parameter DEF_DIV, default 10, giving the post-reset divisor; the post-reset high count SHALL be DEF_DIV/2 (floor).
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  NUM_CH  per-channel run enable.
REQ-007 load  input  NUM_CH  per-channel one-cycle request to capture new settings.
REQ-008 div_val  input  NUM_CH*WIDTH  requested period in clk_in cycles; channel i uses slice [i*WIDTH +: WIDTH].
REQ-009 high_val  input  NUM_CH*WIDTH  requested high-phase length in clk_in cycles; same slicing.
REQ-010 clk_out  output  NUM_CH  registered divided clock per channel.
REQ-011 tick  output  NUM_CH  one-cycle pulse coincident with each 0->1 transition of clk_out.
REQ-012 load_ack  output  NUM_CH  one-cycle pulse in the cycle new settings become active.

Function
REQ-013 Each channel SHALL hold an active divisor (adiv), an active high count (ahigh), shadow copies of both, a pending flag, and a counter cnt.
REQ-014 When en=1, cnt SHALL count 0..eff_div-1 and then wrap to 0, where eff_div = max(adiv, 2).
REQ-015 clk_out SHALL be a register loaded each cycle with (en && cnt < ahigh); it lags cnt by exactly 1 cycle.
REQ-016 If ahigh=0, clk_out SHALL stay 0; if ahigh>=eff_div, clk_out SHALL stay 1 while enabled; tick SHALL then fire only on the 0->1 transition at enable.
REQ-017 A load pulse SHALL copy that channel's div_val and high_val slices into the shadow registers and set pending.
REQ-018 A load while pending is already set SHALL overwrite the shadow registers; a single ack SHALL result.
REQ-019 Pending settings SHALL move into adiv/ahigh at the wrap cycle (cnt=eff_div-1), or in the next cycle when en=0; this gives no partial or glitched periods.
REQ-020 A load in the same cycle as a wrap SHALL take effect at that wrap using the newly presented values.
REQ-021 load_ack SHALL pulse for exactly 1 cycle in the cycle adiv/ahigh update, and pending SHALL clear in that same cycle.
REQ-022 When en=0, cnt SHALL be held at 0 and clk_out SHALL go to 0 on the next edge; tick SHALL stay 0.
REQ-023 On en 0->1, the period SHALL start at cnt=0, and clk_out SHALL rise 1 cycle later if ahigh>0.
REQ-024 When en 1->0 mid-period, the period SHALL be abandoned, with no completion of the high phase.
REQ-025 Channels SHALL be fully independent; no cross-channel timing relation is guaranteed.

Reset
REQ-026 While rst=1, every channel SHALL force cnt=0, adiv=DEF_DIV, ahigh=DEF_DIV/2, shadow = active, pending=0, clk_out=0, tick=0 and load_ack=0.
REQ-027 Reset asserted mid-period SHALL discard any pending load without issuing an ack.
REQ-028 The first period after rst deasserts with en=1 SHALL begin at cnt=0.

Structure
REQ-029 A shared package clk_div_pkg SHALL hold the WIDTH/NUM_CH limits, DEF_DIV, and a channel-settings struct {div, high}.
REQ-030 One sub-module, clk_div_chan, SHALL implement a single channel; the top SHALL generate NUM_CH instances and do the bus slicing only.
REQ-031 The block SHALL contain no combinational path from any input to clk_out, tick or load_ack.

Verification
REQ-032 Reset release with en=1 and no load -> clk_out period 10 cycles, high for 5, tick every 10 cycles.
REQ-033 Load div=7, high=2 mid-period -> current 10-cycle period completes, load_ack at its wrap, then periods are 7 cycles with 2 high.
REQ-034 Set div=1 then div=0 -> behaves as div 2: clk_out toggles every cycle; high=0 -> clk_out constant 0 with no tick.
REQ-035 Two loads 3 cycles apart within one period, div 12 then div 4 -> single ack at wrap, new period is 4 cycles.
REQ-036 Drop en at cnt=3, load div=6 and high=3 while disabled, then re-raise en -> clk_out 0 the cycle after en drops, ack one cycle after the load, first 6-cycle period starts at re-enable.
REQ-037 Assert rst with a load pending on channel 1 while channel 0 runs div 3 -> no ack, both channels return to div 10/high 5, and channel 0 stays unaffected by channel 1 traffic before the reset.
